// File: rtl/rv32i_mc_if.sv
// Memory port bundle for rv32i_mc: request/acknowledge handshake
// with byte strobes; the core is master, the memory is slave.
interface rv32i_mc_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/rv32i_mc.sv
// Multi-cycle RV32I/RV32E core, FETCH/EXEC/MEM/TRAP over one memory port.
// Define RV32I_MISALIGN_TRAP_EN to trap on misaligned accesses/targets.
module rv32i_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    rv32i_mc_if.master  mem,
    output logic [31:0] pc_o,
    output logic [31:0] instret,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        TRAP  = 2'd3
    } state_t;

    localparam int AW = (NREGS <= 16) ? 4 : 5;

    state_t      state_q;
    logic [31:0] pc_q, ir_q, instret_q, ea_q, sd_q;
    logic        trap_q;
    logic [1:0]  cause_q;

    logic [31:0] rf [NREGS];

    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    assign op  = ir_q[6:0];
    assign rd  = ir_q[11:7];
    assign f3  = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign f7  = ir_q[31:25];

    logic op_lui, op_auipc, op_jal, op_jalr, op_br;
    logic op_ld, op_st, op_imm, op_reg, op_fence, op_sys;
    assign op_lui   = op == 7'b0110111;
    assign op_auipc = op == 7'b0010111;
    assign op_jal   = op == 7'b1101111;
    assign op_jalr  = op == 7'b1100111;
    assign op_br    = op == 7'b1100011;
    assign op_ld    = op == 7'b0000011;
    assign op_st    = op == 7'b0100011;
    assign op_imm   = op == 7'b0010011;
    assign op_reg   = op == 7'b0110011;
    assign op_fence = op == 7'b0001111;
    assign op_sys   = op == 7'b1110011;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                    ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'd0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                    ir_q[20], ir_q[30:21], 1'b0};

    logic [31:0] rs1v, rs2v;
    assign rs1v = (rs1 == 5'd0) ? 32'd0 : rf[rs1[AW-1:0]];
    assign rs2v = (rs2 == 5'd0) ? 32'd0 : rf[rs2[AW-1:0]];

    function automatic logic reg_ok(input logic [4:0] r);
        return (NREGS == 32) || !r[4];
    endfunction

    logic [31:0] alu_b, alu_y;
    assign alu_b = op_reg ? rs2v : imm_i;

    always_comb begin
        alu_y = 32'd0;
        case (f3)
            3'd0: alu_y = (op_reg && f7[5]) ? rs1v - alu_b
                                            : rs1v + alu_b;
            3'd1: alu_y = rs1v << alu_b[4:0];
            3'd2: alu_y = {31'd0, $signed(rs1v) < $signed(alu_b)};
            3'd3: alu_y = {31'd0, rs1v < alu_b};
            3'd4: alu_y = rs1v ^ alu_b;
            3'd5: alu_y = f7[5] ? $signed(rs1v) >>> alu_b[4:0]
                                : rs1v >> alu_b[4:0];
            3'd6: alu_y = rs1v | alu_b;
            3'd7: alu_y = rs1v & alu_b;
            default: alu_y = 32'd0;
        endcase
    end

    logic take;
    always_comb begin
        take = 1'b0;
        case (f3)
            3'd0: take = rs1v == rs2v;
            3'd1: take = rs1v != rs2v;
            3'd4: take = $signed(rs1v) < $signed(rs2v);
            3'd5: take = $signed(rs1v) >= $signed(rs2v);
            3'd6: take = rs1v < rs2v;
            3'd7: take = rs1v >= rs2v;
            default: take = 1'b0;
        endcase
    end

    logic        legal, use_rd, use_rs1, use_rs2, wr, jump;
    logic [31:0] wd, npc;

    always_comb begin
        legal   = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr      = 1'b0;
        jump    = 1'b0;
        wd      = alu_y;
        npc     = pc_q + 32'd4;
        unique case (1'b1)
            op_lui: begin
                legal = 1'b1; use_rd = 1'b1; wr = 1'b1;
                wd = imm_u;
            end
            op_auipc: begin
                legal = 1'b1; use_rd = 1'b1; wr = 1'b1;
                wd = pc_q + imm_u;
            end
            op_jal: begin
                legal = 1'b1; use_rd = 1'b1; wr = 1'b1;
                wd = pc_q + 32'd4;
                npc = pc_q + imm_j; jump = 1'b1;
            end
            op_jalr: begin
                legal = f3 == 3'd0;
                use_rd = 1'b1; use_rs1 = 1'b1; wr = 1'b1;
                wd = pc_q + 32'd4;
                npc = (rs1v + imm_i) & ~32'd1; jump = 1'b1;
            end
            op_br: begin
                legal = f3[2:1] != 2'b01;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (take) begin
                    npc = pc_q + imm_b; jump = 1'b1;
                end
            end
            op_ld: begin
                legal = f3[1:0] != 2'b11 && f3[2:1] != 2'b11;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            op_st: begin
                legal = !f3[2] && f3[1:0] != 2'b11;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            op_imm: begin
                legal = (f3 == 3'd1) ? f7 == 7'h00 :
                        (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) :
                        1'b1;
                use_rd = 1'b1; use_rs1 = 1'b1; wr = 1'b1;
            end
            op_reg: begin
                legal = f7 == 7'h00 ||
                        (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                wr = 1'b1;
            end
            op_fence: legal = f3 == 3'd0;
            op_sys:   legal = ir_q == 32'h0000_0073 ||
                              ir_q == 32'h0010_0073;
            default:  legal = 1'b0;
        endcase
    end

    logic regs_ok;
    assign regs_ok = (!use_rd  || reg_ok(rd))  &&
                     (!use_rs1 || reg_ok(rs1)) &&
                     (!use_rs2 || reg_ok(rs2));

    logic [31:0] ea_raw, ea_eff, npc_eff, st_data;
    logic        mis;
    assign ea_raw = rs1v + (op_st ? imm_s : imm_i);

`ifdef RV32I_MISALIGN_TRAP_EN
    logic mis_ls;
    assign mis_ls  = (f3[1:0] == 2'b01 && ea_raw[0]) ||
                     (f3[1:0] == 2'b10 && ea_raw[1:0] != 2'b00);
    assign mis     = (jump && npc[1:0] != 2'b00) ||
                     ((op_ld || op_st) && mis_ls);
    assign npc_eff = npc;
    assign ea_eff  = ea_raw;
`else
    assign mis     = 1'b0;
    assign npc_eff = jump ? {npc[31:2], 2'b00} : npc;
    assign ea_eff  = (f3[1:0] == 2'b01) ? {ea_raw[31:1], 1'b0} :
                     (f3[1:0] == 2'b10) ? {ea_raw[31:2], 2'b00} :
                     ea_raw;
`endif

    // Store data is replicated so every lane the strobe may pick is valid.
    assign st_data = (f3[1:0] == 2'b00) ? {4{rs2v[7:0]}}  :
                     (f3[1:0] == 2'b01) ? {2{rs2v[15:0]}} : rs2v;

    logic [31:0] lane, ld_data;
    assign lane = mem.mem_rdata >> {ea_q[1:0], 3'b000};

    always_comb begin
        ld_data = mem.mem_rdata;
        case (f3)
            3'd0:    ld_data = {{24{lane[7]}}, lane[7:0]};
            3'd1:    ld_data = {{16{lane[15]}}, lane[15:0]};
            3'd4:    ld_data = {24'd0, lane[7:0]};
            3'd5:    ld_data = {16'd0, lane[15:0]};
            default: ld_data = mem.mem_rdata;
        endcase
    end

    logic exec_ok, ls;
    assign ls      = op_ld || op_st;
    assign exec_ok = legal && regs_ok && !op_sys && !mis;

    logic        rf_we;
    logic [31:0] rf_wd;
    assign rf_we = (state_q == EXEC && exec_ok && !ls && wr) ||
                   (state_q == MEM && mem.mem_ack && op_ld);
    assign rf_wd = (state_q == MEM) ? ld_data : wd;

    always_ff @(posedge clk) begin
        if (rf_we && rd != 5'd0)
            rf[rd[AW-1:0]] <= rf_wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            instret_q <= 32'd0;
            trap_q    <= 1'b0;
            cause_q   <= 2'd0;
            ea_q      <= 32'd0;
            sd_q      <= 32'd0;
        end else begin
            unique case (state_q)
                FETCH: if (mem.mem_ack) begin
                    ir_q    <= mem.mem_rdata;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (!(legal && regs_ok)) begin
                        state_q <= TRAP; trap_q <= 1'b1;
                        cause_q <= 2'd0;
                    end else if (op_sys) begin
                        state_q <= TRAP; trap_q <= 1'b1;
                        cause_q <= 2'd2;
                    end else if (mis) begin
                        state_q <= TRAP; trap_q <= 1'b1;
                        cause_q <= 2'd1;
                    end else if (ls) begin
                        ea_q    <= ea_eff;
                        sd_q    <= st_data;
                        state_q <= MEM;
                    end else begin
                        pc_q      <= npc_eff;
                        instret_q <= instret_q + 32'd1;
                        state_q   <= FETCH;
                    end
                end
                MEM: if (mem.mem_ack) begin
                    pc_q      <= pc_q + 32'd4;
                    instret_q <= instret_q + 32'd1;
                    state_q   <= FETCH;
                end
                TRAP: ;
                default: state_q <= TRAP;
            endcase
        end
    end

    logic [3:0] strb;
    always_comb begin
        case (f3[1:0])
            2'b00:   strb = 4'b0001 << ea_q[1:0];
            2'b01:   strb = 4'b0011 << ea_q[1:0];
            default: strb = 4'b1111;
        endcase
    end

    // Request gated by rst_n so an abandoned transfer drops at once.
    assign mem.mem_req   = rst_n && (state_q == FETCH || state_q == MEM);
    assign mem.mem_we    = state_q == MEM && op_st;
    assign mem.mem_addr  = (state_q == MEM) ? {ea_q[31:2], 2'b00} : pc_q;
    assign mem.mem_wdata = mem.mem_we ? sd_q : 32'd0;
    assign mem.mem_wstrb = mem.mem_we ? strb : 4'b0000;

    assign pc_o       = pc_q;
    assign instret    = instret_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state      = state_q;
endmodule

// File: tb/tb_rv32i_mc.sv
// Directed bench for rv32i_mc: wait-state memory model, store/fetch log,
// second RV32E instance for the register-range trap.
module tb_rv32i_mc;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv32i_mc_if mif ();
    rv32i_mc_if mb ();

    logic [31:0] pc_a, ir_a, pc_b, ir_b;
    logic        trap_a, trap_b;
    logic [1:0]  cause_a, cause_b, st_a, st_b;

    rv32i_mc #(.RESET_PC(32'h100), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem(mif),
        .pc_o(pc_a), .instret(ir_a), .trap(trap_a),
        .trap_cause(cause_a), .state(st_a)
    );

    rv32i_mc #(.RESET_PC(32'h0), .NREGS(16)) dut_e (
        .clk(clk), .rst_n(rst_n), .mem(mb),
        .pc_o(pc_b), .instret(ir_b), .trap(trap_b),
        .trap_cause(cause_b), .state(st_b)
    );

    assign mb.mem_rdata = 32'h00100A13;
    assign mb.mem_ack   = mb.mem_req;

    logic [31:0] mem [0:1023];
    int ws = 0;
    int cnt;
    int n_chk = 0;
    int n_fail = 0;
    int unstable = 0;
    logic        held;
    logic [68:0] snap;
    logic [31:0] fa_q[$], sa_q[$], sd_q[$];
    logic [3:0]  ss_q[$];
    int          sl_q[$], ll_q[$];

    assign mif.mem_ack   = mif.mem_req && (cnt == ws);
    assign mif.mem_rdata = mem[mif.mem_addr[11:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 0;
            held <= 1'b0;
        end else if (mif.mem_req) begin
            if (held && snap !== {mif.mem_we, mif.mem_addr,
                                  mif.mem_wdata, mif.mem_wstrb})
                unstable++;
            if (mif.mem_ack) begin
                cnt  <= 0;
                held <= 1'b0;
                if (st_a == 2'd0) fa_q.push_back(mif.mem_addr);
                else if (mif.mem_we) begin
                    sa_q.push_back(mif.mem_addr);
                    sd_q.push_back(mif.mem_wdata);
                    ss_q.push_back(mif.mem_wstrb);
                    sl_q.push_back(cnt + 1);
                    for (int b = 0; b < 4; b++)
                        if (mif.mem_wstrb[b])
                            mem[mif.mem_addr[11:2]][8*b +: 8]
                                <= mif.mem_wdata[8*b +: 8];
                end else ll_q.push_back(cnt + 1);
            end else begin
                cnt  <= cnt + 1;
                held <= 1'b1;
                snap <= {mif.mem_we, mif.mem_addr,
                         mif.mem_wdata, mif.mem_wstrb};
            end
        end else held <= 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1,
                                          f3, rd, op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, rs1,
                                          rs2, f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, rs1,
                                          rs2, f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0],
                imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:0] imm, rd, op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        mem[a[11:2]] = w;
    endtask

    initial begin
        int i;
        int n;
        rst_n = 1'b0;
        for (int k = 0; k < 1024; k++) mem[k] = 32'd0;
        put(32'h100, enc_i(5, 0, 0, 1, 32'h13));
        put(32'h104, enc_i(-7, 1, 0, 2, 32'h13));
        put(32'h108, enc_s(32'h300, 0, 2, 2));
        put(32'h10C, enc_u(32'hDEADC, 4, 32'h37));
        put(32'h110, enc_i(-273, 4, 0, 4, 32'h13));
        put(32'h114, enc_s(32'h200, 0, 4, 2));
        put(32'h118, enc_i(32'h201, 0, 0, 3, 32'h03));
        put(32'h11C, enc_s(32'h304, 0, 3, 2));
        put(32'h120, enc_i(32'hA5, 0, 0, 5, 32'h13));
        put(32'h124, enc_s(32'h203, 0, 5, 0));
        put(32'h128, enc_i(32'h33, 0, 0, 7, 32'h13));
        put(32'h12C, enc_i(32'h10, 0, 0, 0, 32'h67));
        put(32'h010, enc_b(-8, 0, 0, 0));
        put(32'h008, enc_b(8, 0, 0, 1));
        put(32'h00C, enc_i(0, 7, 0, 6, 32'h67));
        put(32'h030, enc_s(32'h308, 0, 6, 2));
        put(32'h034, 32'h0000_0073);

        repeat (2) @(negedge clk);
        chk("rst_state", {30'd0, st_a}, 32'd0);
        chk("rst_pc", pc_a, 32'h100);
        chk("rst_instret", ir_a, 32'd0);
        chk("rst_trap", {31'd0, trap_a}, 32'd0);
        chk("rst_cause", {30'd0, cause_a}, 32'd0);
        chk("rst_req", {31'd0, mif.mem_req}, 32'd0);

        rst_n = 1'b1;
        #1;
        chk("first_req", {31'd0, mif.mem_req}, 32'd1);
        chk("first_addr", mif.mem_addr, 32'h100);
        chk("fetch_strb", {28'd0, mif.mem_wstrb}, 32'd0);

        repeat (4) @(negedge clk);
        chk("instret_4cyc", ir_a, 32'd2);
        chk("pc_4cyc", pc_a, 32'h108);
        chk("e_trap", {31'd0, trap_b}, 32'd1);
        chk("e_cause", {30'd0, cause_b}, 32'd0);
        chk("e_pc", pc_b, 32'h0);
        chk("e_req", {31'd0, mb.mem_req}, 32'd0);
        chk("e_instret", ir_b, 32'd0);
        ws = 3;

        i = 0;
        while (!trap_a && i < 600) begin
            @(negedge clk);
            i++;
        end
        chk("wait_trap", {31'd0, trap_a}, 32'd1);
        chk("trap_req", {31'd0, mif.mem_req}, 32'd0);
        chk("trap_state", {30'd0, st_a}, 32'd3);
        chk("sw_addr", sa_q[1], 32'h200);
        chk("sw_strb", {28'd0, ss_q[1]}, 32'hF);
        chk("sw_data", sd_q[1], 32'hDEADBEEF);
        chk("sw_len", sl_q[1], 32'd4);
        chk("lb_len", ll_q[0], 32'd4);
        chk("sb_addr", sa_q[3], 32'h200);
        chk("sb_strb", {28'd0, ss_q[3]}, 32'h8);
        chk("sb_lane", {24'd0, sd_q[3][31:24]}, 32'hA5);
        chk("mem_x2", mem[10'hC0], 32'hFFFF_FFFE);
        chk("mem_x3", mem[10'hC1], 32'hFFFF_FFBE);
        chk("mem_200", mem[10'h80], 32'hA5ADBEEF);
        chk("stable", unstable, 32'd0);
        n = fa_q.size();
`ifdef RV32I_MISALIGN_TRAP_EN
        chk("trap_cause", {30'd0, cause_a}, 32'd1);
        chk("trap_pc", pc_a, 32'h0C);
        chk("trap_instret", ir_a, 32'd14);
        chk("n_stores", sa_q.size(), 32'd4);
        chk("fetch_jalr", fa_q[n-1], 32'h0C);
        chk("fetch_bne", fa_q[n-2], 32'h08);
        chk("fetch_beq", fa_q[n-3], 32'h10);
`else
        chk("trap_cause", {30'd0, cause_a}, 32'd2);
        chk("trap_pc", pc_a, 32'h34);
        chk("trap_instret", ir_a, 32'd16);
        chk("mem_x6", mem[10'hC2], 32'h10);
        chk("fetch_ecall", fa_q[n-1], 32'h34);
        chk("fetch_jalr_tgt", fa_q[n-2], 32'h30);
        chk("fetch_bne_nt", fa_q[n-3], 32'h0C);
        chk("fetch_beq_tk", fa_q[n-4], 32'h08);
        chk("fetch_beq", fa_q[n-5], 32'h10);
`endif

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        i = 0;
        while (!(st_a == 2'd2 && !mif.mem_we) && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("wait_load", {31'd0, st_a == 2'd2 && !mif.mem_we}, 32'd1);
        chk("pre_rst_instret", ir_a, 32'd6);
        chk("load_addr", mif.mem_addr, 32'h200);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_req", {31'd0, mif.mem_req}, 32'd0);
        chk("abort_instret", ir_a, 32'd0);
        chk("abort_pc", pc_a, 32'h100);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("refetch_req", {31'd0, mif.mem_req}, 32'd1);
        chk("refetch_addr", mif.mem_addr, 32'h100);
        chk("refetch_instret", ir_a, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
